serial_frame_tx: RTL and testbench

SERIAL_FRAME_TX -- requirements
Module: serial_frame_tx

---
 rtl/serial_pkg.sv | 18 +
 rtl/bit_timer.sv | 30 +++
 rtl/serial_frame_tx.sv | 139 +++++++++++++
 tb/tb_serial_frame_tx.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the serial transmitter and the matching receiver.
// Holds the 3-bit state encoding and the default frame parameters.
package serial_pkg;

    localparam int DEF_WIDTH        = 8;
    localparam int DEF_CLKS_PER_BIT = 4;
    localparam int DEF_PARITY_EN    = 1;
    localparam int DEF_PARITY_ODD   = 0;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_START  = 3'd1;
    localparam state_t ST_DATA   = 3'd2;
    localparam state_t ST_PARITY = 3'd3;
    localparam state_t ST_STOP   = 3'd4;

endpackage

// File: rtl/bit_timer.sv
// Bit-period down-counter: reload on load, tick when the count reaches zero.
// With CLKS_PER_BIT=1 the tick is asserted in the cycle right after a load.
module bit_timer
    import serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic tick
);

    localparam logic [7:0] RELOAD = 8'(CLKS_PER_BIT - 1);

    logic [7:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= RELOAD;
        end else if (count != 8'd0) begin
            count <= count - 8'd1;
        end
    end

    assign tick = (count == 8'd0);

endmodule

// File: rtl/serial_frame_tx.sv
// Parallel-to-serial frame transmitter: start bit, LSB-first data,
// optional parity bit, stop bit. All outputs come straight from flops.
module serial_frame_tx
    import serial_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int PARITY_EN    = DEF_PARITY_EN,
    parameter int PARITY_ODD   = DEF_PARITY_ODD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             tx_out,
    output logic             busy,
    output logic             done
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    state_t             state;
    state_t             state_n;
    logic [WIDTH-1:0]   shift;
    logic [WIDTH-1:0]   shift_n;
    logic [WIDTH-1:0]   shifted;
    logic [IDX_W-1:0]   bit_idx;
    logic [IDX_W-1:0]   bit_idx_n;
    logic               parity;
    logic               parity_n;
    logic               tx_n;
    logic               done_n;
    logic               timer_load;
    logic               tick;

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk (clk),
        .rst (rst),
        .load(timer_load),
        .tick(tick)
    );

    assign shifted = shift >> 1;

    always_comb begin
        state_n    = state;
        shift_n    = shift;
        bit_idx_n  = bit_idx;
        parity_n   = parity;
        tx_n       = tx_out;
        done_n     = 1'b0;
        timer_load = 1'b0;
        unique case (state)
            ST_IDLE: begin
                tx_n = 1'b1;
                if (load_valid) begin
                    state_n    = ST_START;
                    tx_n       = 1'b0;
                    shift_n    = data_in;
                    bit_idx_n  = '0;
                    parity_n   = (^data_in) ^ (PARITY_ODD != 0);
                    timer_load = 1'b1;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_n    = ST_DATA;
                    tx_n       = shift[0];
                    timer_load = 1'b1;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    timer_load = 1'b1;
                    if (bit_idx == IDX_LAST) begin
                        if (PARITY_EN != 0) begin
                            state_n = ST_PARITY;
                            tx_n    = parity;
                        end else begin
                            state_n = ST_STOP;
                            tx_n    = 1'b1;
                        end
                    end else begin
                        // Next data bit is bit 0 of the word after shifting.
                        bit_idx_n = bit_idx + IDX_ONE;
                        shift_n   = shifted;
                        tx_n      = shifted[0];
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    state_n    = ST_STOP;
                    tx_n       = 1'b1;
                    timer_load = 1'b1;
                end
            end
            ST_STOP: begin
                tx_n = 1'b1;
                if (tick) begin
                    state_n = ST_IDLE;
                    done_n  = 1'b1;
                end
            end
            default: begin
                state_n = ST_IDLE;
                tx_n    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            shift      <= '0;
            bit_idx    <= '0;
            parity     <= 1'b0;
            tx_out     <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            load_ready <= 1'b1;
        end else begin
            state      <= state_n;
            shift      <= shift_n;
            bit_idx    <= bit_idx_n;
            parity     <= parity_n;
            tx_out     <= tx_n;
            busy       <= (state_n != ST_IDLE);
            done       <= done_n;
            load_ready <= (state_n == ST_IDLE);
        end
    end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Scoreboard bench: three builds (even parity, odd parity, no parity).
// Expected {done,busy,tx} per cycle is queued when a load is driven.
module tb_serial_frame_tx;

    localparam int C = 4;

    logic       clk;
    logic       rst;
    logic [7:0] d0, d1, d2;
    logic       v0, v1, v2;
    logic       r0, r1, r2;
    logic       t0, t1, t2;
    logic       b0, b1, b2;
    logic       dn0, dn1, dn2;

    logic [2:0] exp_q[$];
    int         n_checks;
    int         n_fail;

    serial_frame_tx #(
        .WIDTH(8), .CLKS_PER_BIT(C), .PARITY_EN(1), .PARITY_ODD(0)
    ) u_even (
        .clk(clk), .rst(rst), .data_in(d0), .load_valid(v0),
        .load_ready(r0), .tx_out(t0), .busy(b0), .done(dn0)
    );

    serial_frame_tx #(
        .WIDTH(8), .CLKS_PER_BIT(C), .PARITY_EN(1), .PARITY_ODD(1)
    ) u_odd (
        .clk(clk), .rst(rst), .data_in(d1), .load_valid(v1),
        .load_ready(r1), .tx_out(t1), .busy(b1), .done(dn1)
    );

    serial_frame_tx #(
        .WIDTH(8), .CLKS_PER_BIT(C), .PARITY_EN(0), .PARITY_ODD(0)
    ) u_nopar (
        .clk(clk), .rst(rst), .data_in(d2), .load_valid(v2),
        .load_ready(r2), .tx_out(t2), .busy(b2), .done(dn2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model entries are {done, busy, tx}.
    function automatic void push_bit(input logic b);
        for (int k = 0; k < C; k++) exp_q.push_back({2'b01, b});
    endfunction

    function automatic void push_frame(input logic [7:0] w, input bit pen,
                                       input bit odd);
        push_bit(1'b0);
        for (int k = 0; k < 8; k++) push_bit(w[k]);
        if (pen) push_bit((^w) ^ odd);
        push_bit(1'b1);
        exp_q.push_back(3'b101);
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if ({t0, t1, t2} !== 3'b111) begin
            n_fail++;
            $display("FAIL reset_tx got %b expected 111", {t0, t1, t2});
        end
        n_checks++;
        if ({b0, b1, b2} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_busy got %b expected 000", {b0, b1, b2});
        end
        n_checks++;
        if ({dn0, dn1, dn2} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_done got %b expected 000", {dn0, dn1, dn2});
        end
        n_checks++;
        if ({r0, r1, r2} !== 3'b111) begin
            n_fail++;
            $display("FAIL reset_ready got %b expected 111", {r0, r1, r2});
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_frame_a5();
        logic [2:0] e;
        int i;
        d0 = 8'hA5;
        v0 = 1'b1;
        push_frame(8'hA5, 1'b1, 1'b0);
        exp_q.push_back(3'b001);
        @(negedge clk);
        v0 = 1'b0;
        d0 = 8'h00;
        i = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if ({dn0, b0, t0} !== e) begin
                n_fail++;
                $display("FAIL a5_frame cyc %0d got %b expected %b",
                         i, {dn0, b0, t0}, e);
            end
            i++;
            if (exp_q.size() > 0) @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic test_parity();
        logic [2:0] e;
        int i;
        d0 = 8'h07;
        v0 = 1'b1;
        push_frame(8'h07, 1'b1, 1'b0);
        @(negedge clk);
        v0 = 1'b0;
        i = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if ({dn0, b0, t0} !== e) begin
                n_fail++;
                $display("FAIL even_07 cyc %0d got %b expected %b",
                         i, {dn0, b0, t0}, e);
            end
            i++;
            if (exp_q.size() > 0) @(negedge clk);
        end
        @(negedge clk);
        d1 = 8'h07;
        v1 = 1'b1;
        push_frame(8'h07, 1'b1, 1'b1);
        @(negedge clk);
        v1 = 1'b0;
        i = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if ({dn1, b1, t1} !== e) begin
                n_fail++;
                $display("FAIL odd_07 cyc %0d got %b expected %b",
                         i, {dn1, b1, t1}, e);
            end
            i++;
            if (exp_q.size() > 0) @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic test_no_parity();
        logic [2:0] e;
        int i;
        d2 = 8'h81;
        v2 = 1'b1;
        push_frame(8'h81, 1'b0, 1'b0);
        exp_q.push_back(3'b001);
        @(negedge clk);
        v2 = 1'b0;
        i = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if ({dn2, b2, t2} !== e) begin
                n_fail++;
                $display("FAIL nopar_81 cyc %0d got %b expected %b",
                         i, {dn2, b2, t2}, e);
            end
            i++;
            if (exp_q.size() > 0) @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [2:0] e;
        int i;
        d0 = 8'h3C;
        v0 = 1'b1;
        push_frame(8'h3C, 1'b1, 1'b0);
        push_frame(8'hC3, 1'b1, 1'b0);
        exp_q.push_back(3'b001);
        @(negedge clk);
        d0 = 8'hC3;
        i = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if ({dn0, b0, t0} !== e) begin
                n_fail++;
                $display("FAIL b2b cyc %0d got %b expected %b",
                         i, {dn0, b0, t0}, e);
            end
            if (i == 45) v0 = 1'b0;
            i++;
            if (exp_q.size() > 0) @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic test_ignore_busy();
        logic [2:0] e;
        int i;
        d0 = 8'h0F;
        v0 = 1'b1;
        push_frame(8'h0F, 1'b1, 1'b0);
        exp_q.push_back(3'b001);
        @(negedge clk);
        v0 = 1'b0;
        i = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if ({dn0, b0, t0} !== e) begin
                n_fail++;
                $display("FAIL ignore_busy cyc %0d got %b expected %b",
                         i, {dn0, b0, t0}, e);
            end
            if (i == 10) begin
                v0 = 1'b1;
                d0 = 8'hAA;
            end
            if (i == 11) v0 = 1'b0;
            i++;
            if (exp_q.size() > 0) @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic test_abort();
        logic [2:0] e;
        int i;
        d0 = 8'hFF;
        v0 = 1'b1;
        @(negedge clk);
        v0 = 1'b0;
        repeat (17) @(negedge clk);
        n_checks++;
        if ({b0, t0} !== 2'b11) begin
            n_fail++;
            $display("FAIL abort_pre got %b expected 11", {b0, t0});
        end
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if ({dn0, b0, t0, r0} !== 4'b0011) begin
            n_fail++;
            $display("FAIL abort_async got %b expected 0011",
                     {dn0, b0, t0, r0});
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            n_checks++;
            if ({dn0, b0, t0} !== 3'b001) begin
                n_fail++;
                $display("FAIL abort_quiet cyc %0d got %b expected 001",
                         k, {dn0, b0, t0});
            end
        end
        d0 = 8'h5A;
        v0 = 1'b1;
        push_frame(8'h5A, 1'b1, 1'b0);
        exp_q.push_back(3'b001);
        @(negedge clk);
        v0 = 1'b0;
        i = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if ({dn0, b0, t0} !== e) begin
                n_fail++;
                $display("FAIL after_abort cyc %0d got %b expected %b",
                         i, {dn0, b0, t0}, e);
            end
            i++;
            if (exp_q.size() > 0) @(negedge clk);
        end
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        d0 = '0; d1 = '0; d2 = '0;
        v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
        test_reset();
        test_frame_a5();
        test_parity();
        test_no_parity();
        test_back_to_back();
        test_ignore_busy();
        test_abort();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
